// File: rtl/core_pkg.sv
// Shared core-wide types and constants for the fetch sequencing logic.
package core_pkg;

  localparam int XLEN               = 32;
  localparam int FETCH_FLUSH_CYCLES = 2;

  // Numeric order is priority order; SRC_BOOT ranks below every real request.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_BOOT = 3'd1,
    SRC_DEC  = 3'd2,
    SRC_MISP = 3'd3,
    SRC_EXC  = 3'd4
  } redir_src_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDIR,
    ST_FLUSH,
    ST_RUN,
    ST_HALTED
  } fctrl_state_e;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority select of the three redirect requesters: exception > mispredict > decode.
module redirect_arb #(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic                 exc_valid,
  input  logic [XLEN-1:0]      exc_pc,
  input  logic                 misp_valid,
  input  logic [XLEN-1:0]      misp_pc,
  input  logic                 dec_redir_valid,
  input  logic [XLEN-1:0]      dec_redir_pc,
  output logic                 valid,
  output logic [XLEN-1:0]      pc,
  output core_pkg::redir_src_e src
);
  import core_pkg::*;

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
    valid = 1'b0;
    pc    = '0;
    src   = SRC_NONE;
    if (exc_valid) begin
      valid = 1'b1;
      pc    = exc_pc;
      src   = SRC_EXC;
    end else if (misp_valid) begin
      valid = 1'b1;
      pc    = misp_pc;
      src   = SRC_MISP;
    end else if (dec_redir_valid) begin
      valid = 1'b1;
      pc    = dec_redir_pc;
      src   = SRC_DEC;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: start/halt/resume, stall merge, redirect arbitration and post-redirect flush window.
module fetch_ctrl #(
  parameter int              XLEN         = core_pkg::XLEN,
  parameter logic [XLEN-1:0] BOOT_PC      = '0,
  parameter int              FLUSH_CYCLES = core_pkg::FETCH_FLUSH_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 exc_valid,
  input  logic [XLEN-1:0]      exc_pc,
  input  logic                 misp_valid,
  input  logic [XLEN-1:0]      misp_pc,
  input  logic                 dec_redir_valid,
  input  logic [XLEN-1:0]      dec_redir_pc,
  input  logic                 decode_full,
  output logic                 fetch_en,
  output logic                 stall,
  output logic                 redirect_en,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush_frontend,
  output core_pkg::redir_src_e redirect_src,
  output logic                 halted
);
  import core_pkg::*;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  fctrl_state_e    state, next_state;
  logic [CW-1:0]   flush_cnt;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  redir_src_e      req_src;
  logic            accept;
  logic            load;
  logic [XLEN-1:0] load_pc;
  redir_src_e      load_src;

  redirect_arb #(.XLEN(XLEN)) u_arb (
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .misp_valid      (misp_valid),
    .misp_pc         (misp_pc),
    .dec_redir_valid (dec_redir_valid),
    .dec_redir_pc    (dec_redir_pc),
    .valid           (req_valid),
    .pc              (req_pc),
    .src             (req_src)
  );

  // During a flush only a strictly higher-priority source may restart the redirect.
  assign accept = req_valid && (req_src > redirect_src);
  assign stall  = decode_full && (state == ST_RUN);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_pc    = req_pc;
    load_src   = req_src;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_REDIR;
          load       = 1'b1;
          load_pc    = BOOT_PC;
          load_src   = SRC_BOOT;
        end
      end
      ST_RUN: begin
        if (exc_valid) begin
          next_state = ST_REDIR;
          load       = 1'b1;
        end else if (halt_req) begin
          next_state = ST_HALTED;
        end else if (req_valid) begin
          next_state = ST_REDIR;
          load       = 1'b1;
        end
      end
      ST_REDIR: next_state = ST_FLUSH;
      ST_FLUSH: begin
        if (accept && req_src == SRC_EXC) begin
          next_state = ST_REDIR;
          load       = 1'b1;
        end else if (halt_req) begin
          next_state = ST_HALTED;
        end else if (accept) begin
          next_state = ST_REDIR;
          load       = 1'b1;
        end else if (flush_cnt <= CW'(1)) begin
          next_state = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (exc_valid) begin
          next_state = ST_REDIR;
          load       = 1'b1;
        end else if (start) begin
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state          <= ST_IDLE;
      flush_cnt      <= '0;
      fetch_en       <= 1'b0;
      redirect_en    <= 1'b0;
      flush_frontend <= 1'b0;
      redirect_pc    <= '0;
      redirect_src   <= SRC_NONE;
      halted         <= 1'b0;
    end else begin
      state          <= next_state;
      fetch_en       <= (next_state == ST_RUN);
      redirect_en    <= (next_state == ST_REDIR);
      flush_frontend <= (next_state == ST_REDIR);
      halted         <= (next_state == ST_HALTED);
      if (state == ST_REDIR) begin
        flush_cnt <= CW'(FLUSH_CYCLES);
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - CW'(1);
      end
      if (load) begin
        redirect_pc  <= load_pc;
        redirect_src <= load_src;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table plus randomized run against a behavioural model.
module tb_fetch_ctrl;

  localparam int FC = 2;
  localparam logic [31:0] BOOT = 32'h0;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, exc_valid, misp_valid, dec_redir_valid, decode_full;
  logic [31:0] exc_pc, misp_pc, dec_redir_pc;
  logic        fetch_en, stall, redirect_en, flush_frontend, halted;
  logic [31:0] redirect_pc;
  logic [2:0]  redirect_src;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .BOOT_PC(BOOT), .FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .halt_req        (halt_req),
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .misp_valid      (misp_valid),
    .misp_pc         (misp_pc),
    .dec_redir_valid (dec_redir_valid),
    .dec_redir_pc    (dec_redir_pc),
    .decode_full     (decode_full),
    .fetch_en        (fetch_en),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .flush_frontend  (flush_frontend),
    .redirect_src    (redirect_src),
    .halted          (halted)
  );

  typedef struct {
    bit          rst, st, hlt, exc, misp, dec, dfull;
    logic [31:0] epc, mpc, dpc;
    bit          fe, ren;
    logic [31:0] rpc;
    int          src;
    bit          hl, stl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, st, hlt, exc, misp, dec, dfull,
                     input logic [31:0] epc, mpc, dpc,
                     input bit fe, ren, input logic [31:0] rpc, input int src,
                     input bit hl, stl);
    vec_t v;
    v.rst = rst; v.st = st; v.hlt = hlt; v.exc = exc; v.misp = misp; v.dec = dec; v.dfull = dfull;
    v.epc = epc; v.mpc = mpc; v.dpc = dpc;
    v.fe = fe; v.ren = ren; v.rpc = rpc; v.src = src; v.hl = hl; v.stl = stl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, st, hlt, exc, misp, dec, dfull,
                       input logic [31:0] epc, mpc, dpc);
    reset = rst; start = st; halt_req = hlt; exc_valid = exc; misp_valid = misp;
    dec_redir_valid = dec; decode_full = dfull;
    exc_pc = epc; misp_pc = mpc; dec_redir_pc = dpc;
  endtask

  // Behavioural model: tracks "has booted", "halted", "pulse this cycle" and remaining dead cycles.
  bit          m_started, m_halted, m_pulse;
  int          m_left, m_src;
  logic [31:0] m_pc;

  task automatic fire(input logic [31:0] pc, input int src);
    m_pulse = 1; m_pc = pc; m_src = src; m_left = 0;
  endtask

  task automatic model_step();
    int          win;
    logic [31:0] wpc;
    win = 0; wpc = 0;
    if (exc_valid) begin win = 4; wpc = exc_pc; end
    else if (misp_valid) begin win = 3; wpc = misp_pc; end
    else if (dec_redir_valid) begin win = 2; wpc = dec_redir_pc; end
    if (reset) begin
      m_started = 0; m_halted = 0; m_pulse = 0; m_left = 0; m_src = 0; m_pc = 0;
    end else if (!m_started) begin
      if (start) begin m_started = 1; fire(BOOT, 1); end
    end else if (m_pulse) begin
      m_pulse = 0; m_left = FC;
    end else if (m_halted) begin
      if (exc_valid) begin m_halted = 0; fire(exc_pc, 4); end
      else if (start) m_halted = 0;
    end else if (m_left > 0) begin
      if (win == 4 && m_src < 4) fire(wpc, win);
      else if (halt_req) begin m_halted = 1; m_left = 0; end
      else if (win > m_src) fire(wpc, win);
      else m_left--;
    end else begin
      if (win == 4) fire(wpc, win);
      else if (halt_req) m_halted = 1;
      else if (win > 0) fire(wpc, win);
    end
  endtask

  initial begin
    bit fe_exp;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst st hl ex mi de df   epc      mpc      dpc      fe rn rpc      src hl st
    repeat (3) add(1,0,0,0,0,0,0, 0,0,0,              0,0,0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,                          0,1,0,1,0,0);
    repeat (2) add(0,0,0,0,0,0,0, 0,0,0,               0,0,0,1,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,0,1,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,                          1,0,0,1,0,1);
    add(0,0,0,0,1,1,0, 0,'h100,'h200,                  0,1,'h100,3,0,0);
    add(0,0,0,0,0,1,1, 0,0,'h200,                      0,0,'h100,3,0,0);
    add(0,0,0,0,0,1,0, 0,0,'h200,                      0,0,'h100,3,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,'h100,3,0,0);
    add(0,0,0,0,0,1,0, 0,0,'h40,                       0,1,'h40,2,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,'h40,2,0,0);
    add(0,0,0,0,1,0,0, 0,'h80,0,                       0,1,'h80,3,0,0);
    repeat (2) add(0,0,0,0,0,0,0, 0,0,0,               0,0,'h80,3,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,'h80,3,0,0);
    add(0,0,1,0,1,0,0, 0,'h300,0,                      0,0,'h80,3,1,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,'h80,3,1,0);
    add(0,0,0,0,1,0,1, 0,'h400,0,                      0,0,'h80,3,1,0);
    add(0,1,0,0,0,0,0, 0,0,0,                          1,0,'h80,3,0,0);
    add(0,0,1,0,0,0,0, 0,0,0,                          0,0,'h80,3,1,0);
    add(0,0,0,1,0,0,0, 'hF00,0,0,                      0,1,'hF00,4,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,'hF00,4,0,0);
    add(0,0,0,1,0,0,0, 'h500,0,0,                      0,0,'hF00,4,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,'hF00,4,0,0);
    add(0,0,0,0,0,1,0, 0,0,'h60,                       0,1,'h60,2,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,'h60,2,0,0);
    add(1,0,0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0);
    add(0,0,0,0,1,0,0, 0,'h700,0,                      0,0,0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,                          0,1,0,1,0,0);
    repeat (2) add(0,0,0,0,0,0,0, 0,0,0,               0,0,0,1,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,0,1,0,0);
    add(0,0,1,1,0,0,0, 'h900,0,0,                      0,1,'h900,4,0,0);
    repeat (2) add(0,0,0,0,0,0,0, 0,0,0,               0,0,'h900,4,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          1,0,'h900,4,0,0);
    add(0,0,1,0,0,0,0, 0,0,0,                          0,0,'h900,4,1,0);
    add(0,1,0,1,0,0,0, 'hA00,0,0,                      0,1,'hA00,4,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,                          0,0,'hA00,4,0,0);
    add(0,0,1,0,0,0,0, 0,0,0,                          0,0,'hA00,4,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].hlt, vecs[i].exc, vecs[i].misp, vecs[i].dec,
            vecs[i].dfull, vecs[i].epc, vecs[i].mpc, vecs[i].dpc);
      @(posedge clk); #1;
      check($sformatf("vec%0d fetch_en", i),       fetch_en,       vecs[i].fe);
      check($sformatf("vec%0d redirect_en", i),    redirect_en,    vecs[i].ren);
      check($sformatf("vec%0d flush_frontend", i), flush_frontend, vecs[i].ren);
      check($sformatf("vec%0d redirect_pc", i),    redirect_pc,    vecs[i].rpc);
      check($sformatf("vec%0d redirect_src", i),   redirect_src,   vecs[i].src);
      check($sformatf("vec%0d halted", i),         halted,         vecs[i].hl);
      check($sformatf("vec%0d stall", i),          stall,          vecs[i].stl);
    end

    // Randomized run against the model, starting from a clean reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) < 1, $urandom_range(99) < 12, $urandom_range(99) < 5,
            $urandom_range(99) < 4, $urandom_range(99) < 10, $urandom_range(99) < 10,
            $urandom_range(99) < 30, $urandom, $urandom, $urandom);
      model_step();
      @(posedge clk); #1;
      fe_exp = m_started && !m_halted && !m_pulse && m_left == 0;
      check("rnd fetch_en",       fetch_en,       fe_exp);
      check("rnd redirect_en",    redirect_en,    m_pulse);
      check("rnd flush_frontend", flush_frontend, m_pulse);
      check("rnd redirect_pc",    redirect_pc,    m_pc);
      check("rnd redirect_src",   redirect_src,   m_src);
      check("rnd halted",         halted,         m_halted);
      check("rnd stall",          stall,          decode_full && fe_exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
